// File: rtl/pulse_shaper_if.sv
// rtl/pulse_shaper_if.sv - event/config inputs and shaped-pulse status outputs of pulse_shaper
interface pulse_shaper_if #(
   parameter int CNT_W   = 8,
   parameter int QUEUE_W = 4
);
   logic               pulse_in;
   logic [CNT_W-1:0]   width;
   logic [CNT_W-1:0]   gap;
   logic               retrig_en;
   logic               clr_ovf;
   logic               level_out;
   logic               busy;
   logic [QUEUE_W-1:0] pend_cnt;
   logic               overflow;

   modport master (
      output pulse_in, width, gap, retrig_en, clr_ovf,
      input  level_out, busy, pend_cnt, overflow
   );

   modport slave (
      input  pulse_in, width, gap, retrig_en, clr_ovf,
      output level_out, busy, pend_cnt, overflow
   );
endinterface

// File: rtl/pulse_shaper.sv
// rtl/pulse_shaper.sv - turns event strobes into width/gap shaped level pulses
// Busy events are queued in a saturating counter or, with retrigger, extend the pulse.
module pulse_shaper #(
   parameter int CNT_W   = 8,
   parameter int QUEUE_W = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   pulse_shaper_if.slave  ps
);
   typedef enum logic [1:0] {S_IDLE, S_HIGH, S_GAP} state_t;

   state_t             r_state,  w_state_nxt;
   logic [CNT_W-1:0]   r_timer,  w_timer_nxt;
   logic               r_level,  w_level_nxt;
   logic [QUEUE_W-1:0] r_pend,   w_pend_nxt;
   logic               r_ovf,    w_ovf_nxt;
   logic               w_inc;
   logic               w_dec;
   logic [CNT_W-1:0]   w_wm1;
   logic [CNT_W-1:0]   w_gm1;

   // Timer holds remaining cycles after the current one, so a zero setting still yields one cycle.
   assign w_wm1 = (ps.width == '0) ? '0 : ps.width - CNT_W'(1);
   assign w_gm1 = (ps.gap   == '0) ? '0 : ps.gap   - CNT_W'(1);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_timer <= '0;
         r_level <= 1'b0;
         r_pend  <= '0;
         r_ovf   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_timer <= w_timer_nxt;
         r_level <= w_level_nxt;
         r_pend  <= w_pend_nxt;
         r_ovf   <= w_ovf_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_timer_nxt = r_timer;
      w_level_nxt = r_level;
      w_inc       = 1'b0;
      w_dec       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (ps.pulse_in) begin
               w_state_nxt = S_HIGH;
               w_timer_nxt = w_wm1;
               w_level_nxt = 1'b1;
            end
         end
         S_HIGH: begin
            if (ps.pulse_in && ps.retrig_en) begin
               w_timer_nxt = w_wm1;
            end else begin
               w_inc = ps.pulse_in;
               if (r_timer == '0) begin
                  w_state_nxt = S_GAP;
                  w_timer_nxt = w_gm1;
                  w_level_nxt = 1'b0;
               end else begin
                  w_timer_nxt = r_timer - CNT_W'(1);
               end
            end
         end
         S_GAP: begin
            w_inc = ps.pulse_in;
            if (r_timer == '0) begin
               // An event arriving on the last gap cycle launches immediately.
               if ((r_pend != '0) || w_inc) begin
                  w_state_nxt = S_HIGH;
                  w_timer_nxt = w_wm1;
                  w_level_nxt = 1'b1;
                  w_dec       = 1'b1;
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end else begin
               w_timer_nxt = r_timer - CNT_W'(1);
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_timer_nxt = '0;
            w_level_nxt = 1'b0;
         end
      endcase

      w_pend_nxt = r_pend;
      w_ovf_nxt  = r_ovf;
      if (ps.clr_ovf) begin
         w_ovf_nxt = 1'b0;
      end
      if (w_inc && !w_dec) begin
         if (r_pend == {QUEUE_W{1'b1}}) begin
            w_ovf_nxt = 1'b1;
         end else begin
            w_pend_nxt = r_pend + QUEUE_W'(1);
         end
      end else if (w_dec && !w_inc) begin
         w_pend_nxt = r_pend - QUEUE_W'(1);
      end
   end

   assign ps.level_out = r_level;
   assign ps.busy      = (r_state != S_IDLE);
   assign ps.pend_cnt  = r_pend;
   assign ps.overflow  = r_ovf;
endmodule
